// File: rtl/ram_cycle_ctrl.sv
// 68000 fast-RAM / ROM-shadow bus-cycle controller with wait-state counter and DTACK generation.
// Optional ACK watchdog is enabled by defining ACK_WATCHDOG_EN.
module ram_cycle_ctrl #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic         CLK,
    input  logic         _RST,
    input  logic [23:12] AH,
    input  logic         _AS,
    input  logic         _UDS,
    input  logic         _LDS,
    input  logic         RW,
    input  logic         maprom_on,
    output logic         OVR,
    output logic         DTACK,
    output logic         ramce,
    output logic         ram_oe,
    output logic         ram_we_u,
    output logic         ram_we_l,
    output logic         wd_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
    typedef enum logic [2:0] {C_MISS, C_RAM, C_ROMW, C_ROMR, C_CTRL} cls_t;

    localparam logic [2:0] WS_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    state_t     state, state_n;
    cls_t       cls, cls_n, hit;
    logic       rw_q, rw_n;
    logic [2:0] cnt, cnt_n;

    // Address decode; only used for acceptance and OVR, never for SRAM strobes.
    always_comb begin
        hit = C_MISS;
        if (AH >= 12'hC00 && AH <= 12'hD7F)
            hit = C_RAM;
        else if (AH >= 12'hF80)
            hit = !RW ? C_ROMW : (maprom_on ? C_ROMR : C_MISS);
        else if (AH == 12'hE9C)
            hit = C_CTRL;
    end

`ifdef ACK_WATCHDOG_EN
    localparam logic [3:0] WD_LAST = 4'd14;
    logic [3:0] wd_cnt, wd_cnt_n;
    logic       wd_fire;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cls_n   = cls;
        rw_n    = rw_q;
`ifdef ACK_WATCHDOG_EN
        wd_cnt_n = wd_cnt;
        wd_fire  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!_AS && hit != C_MISS) begin
                    cls_n = hit;
                    rw_n  = RW;
                    if (WAIT_STATES == 0 || hit == C_CTRL) begin
                        state_n = S_ACK;
`ifdef ACK_WATCHDOG_EN
                        wd_cnt_n = 4'd0;
`endif
                    end else begin
                        cnt_n   = WS_LOAD;
                        state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (_AS) begin
                    state_n = S_IDLE;
                end else if (cnt == 3'd0) begin
                    state_n = S_ACK;
`ifdef ACK_WATCHDOG_EN
                    wd_cnt_n = 4'd0;
`endif
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            S_ACK: begin
                if (_AS)
                    state_n = S_IDLE;
`ifdef ACK_WATCHDOG_EN
                // Abort on the clock the count would reach 15, so DTACK is held for 15 clocks.
                else if (wd_cnt == WD_LAST) begin
                    state_n = S_IDLE;
                    wd_fire = 1'b1;
                end else
                    wd_cnt_n = wd_cnt + 4'd1;
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
            cls   <= C_MISS;
            rw_q  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cls   <= cls_n;
            rw_q  <= rw_n;
        end
    end

`ifdef ACK_WATCHDOG_EN
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            wd_cnt <= 4'd0;
            wd_err <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_n;
            wd_err <= wd_fire;
        end
    end
`else
    assign wd_err = 1'b0;
`endif

    assign OVR      = (!_AS && hit != C_MISS) || state != S_IDLE;
    assign DTACK    = state == S_ACK;
    assign ramce    = state != S_IDLE && (cls == C_RAM || cls == C_ROMW || cls == C_ROMR);
    assign ram_oe   = ramce && rw_q;
    assign ram_we_u = ramce && !rw_q && !_UDS;
    assign ram_we_l = ramce && !rw_q && !_LDS;

endmodule

// File: tb/tb_ram_cycle_ctrl.sv
// Directed bench for ram_cycle_ctrl: one instance with WAIT_STATES=1, one with WAIT_STATES=5.
// Output vectors are {OVR, DTACK, ramce, ram_oe, ram_we_u, ram_we_l, wd_err}.
module tb_ram_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] ah;
    logic        as_n, uds_n, lds_n, rw, maprom;

    logic ovr, dtack, ce, oe, weu, wel, wde;
    logic ovr5, dtack5, ce5, oe5, weu5, wel5, wde5;
    logic [6:0] o, o5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign o  = {ovr, dtack, ce, oe, weu, wel, wde};
    assign o5 = {ovr5, dtack5, ce5, oe5, weu5, wel5, wde5};

    ram_cycle_ctrl #(.WAIT_STATES(1)) dut (
        .CLK(clk), ._RST(rst_n), .AH(ah), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n),
        .RW(rw), .maprom_on(maprom), .OVR(ovr), .DTACK(dtack), .ramce(ce),
        .ram_oe(oe), .ram_we_u(weu), .ram_we_l(wel), .wd_err(wde)
    );

    ram_cycle_ctrl #(.WAIT_STATES(5)) dut5 (
        .CLK(clk), ._RST(rst_n), .AH(ah), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n),
        .RW(rw), .maprom_on(maprom), .OVR(ovr5), .DTACK(dtack5), .ramce(ce5),
        .ram_oe(oe5), .ram_we_u(weu5), .ram_we_l(wel5), .wd_err(wde5)
    );

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] a, input logic as_v, input logic rw_v,
                         input logic uds_v, input logic lds_v);
        ah = a; as_n = as_v; rw = rw_v; uds_n = uds_v; lds_n = lds_v;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; maprom = 1'b0;
        drive(12'h000, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("reset_idle", o, 7'b0000000);
        drive(12'hC12, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset_ovr_only", o, 7'b1000000);
        drive(12'hC12, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_reset", o, 7'b0000000);

        // RAM read C12345, one wait state
        drive(12'hC12, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rd_ovr", o, 7'b1000000);
        cyc(); chk("rd_wait", o, 7'b1011000);
        cyc(); chk("rd_ack", o, 7'b1111000);
        cyc(); chk("rd_ack_hold", o, 7'b1111000);
        drive(12'hC12, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rd_as_hi", o, 7'b1111000);
        cyc(); chk("rd_end", o, 7'b0000000);

        // Lower-byte write D00000
        cyc();
        drive(12'hD00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrl_ovr", o, 7'b1000000);
        cyc(); chk("wrl_wait", o, 7'b1010010);
        cyc(); chk("wrl_ack", o, 7'b1110010);
        drive(12'hD00, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(); chk("wrl_end", o, 7'b0000000);

        // ROM read without shadow: no claim
        cyc();
        drive(12'hFC0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("romr_off", o, 7'b0000000);
        cyc(); chk("romr_off_1", o, 7'b0000000);
        cyc(); chk("romr_off_2", o, 7'b0000000);
        drive(12'hFC0, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc();

        // ROM read with shadow; maprom dropping mid-cycle must not matter
        maprom = 1'b1;
        drive(12'hFC0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("romr_on_ovr", o, 7'b1000000);
        cyc(); chk("romr_on_wait", o, 7'b1011000);
        maprom = 1'b0;
        cyc(); chk("romr_on_ack", o, 7'b1111000);
        drive(12'hFC0, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(); chk("romr_on_end", o, 7'b0000000);

        // ROM write, shadow off, word write
        cyc();
        drive(12'hFC0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("romw_ovr", o, 7'b1000000);
        cyc(); chk("romw_wait", o, 7'b1010110);
        cyc(); chk("romw_ack", o, 7'b1110110);
        drive(12'hFC0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(); chk("romw_end", o, 7'b0000000);

        // Control register: immediate ACK, no SRAM
        cyc();
        drive(12'hE9C, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ctrl_ovr", o, 7'b1000000);
        cyc(); chk("ctrl_ack", o, 7'b1100000);
        cyc(); chk("ctrl_ack_hold", o, 7'b1100000);
        drive(12'hE9C, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(); chk("ctrl_end", o, 7'b0000000);

        // CIA address: miss
        cyc();
        drive(12'hBFE, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("miss_0", o, 7'b0000000);
        cyc(); chk("miss_1", o, 7'b0000000);
        drive(12'hBFE, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc();

        // Five wait states: abort in WAIT
        drive(12'hC00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ws5_ovr", o5, 7'b1000000);
        cyc(); chk("ws5_wait_a", o5, 7'b1011000);
        cyc(); chk("ws5_wait_b", o5, 7'b1011000);
        drive(12'hC00, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("ws5_as_hi", o5, 7'b1011000);
        cyc(); chk("ws5_abort", o5, 7'b0000000);
        cyc(); chk("ws5_abort_idle", o5, 7'b0000000);

        // Five wait states: full cycle, DTACK five clocks after acceptance
        drive(12'hC00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); chk("ws5_w0", o5, 7'b1011000);
        for (int i = 1; i <= 4; i++) begin
            cyc(); chk($sformatf("ws5_w%0d", i), o5, 7'b1011000);
        end
        cyc(); chk("ws5_ack", o5, 7'b1111000);
        drive(12'hC00, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(); chk("ws5_end", o5, 7'b0000000);

        // Reset asserted in ACK
        cyc();
        drive(12'hC12, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); cyc(); chk("rst_pre_ack", o, 7'b1111000);
        rst_n = 1'b0;
        #1; chk("rst_in_ack", o, 7'b1000000);
        drive(12'hC12, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc();
        rst_n = 1'b1;
        cyc(); chk("rst_release", o, 7'b0000000);
        drive(12'hC12, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); chk("rst_fresh_wait", o, 7'b1011000);
        cyc(); chk("rst_fresh_ack", o, 7'b1111000);

        // _AS held low 20 clocks into ACK
        for (int k = 1; k <= 20; k++) begin
            logic [6:0] exp;
`ifdef ACK_WATCHDOG_EN
            if (k <= 14)      exp = 7'b1111000;
            else if (k == 15) exp = 7'b1000001;
            else if (k == 16) exp = 7'b1011000;
            else              exp = 7'b1111000;
`else
            exp = 7'b1111000;
`endif
            cyc(); chk($sformatf("wd_k%0d", k), o, exp);
        end
        drive(12'hC12, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(); chk("wd_end", o, 7'b0000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
